filter_match_extract: RTL and testbench

Downstream stage of the first-level shift-or filter in the MSPM string matcher. Accepts the filter's 256-bit per-word result vector (32 byte lanes × 8 bits; a 0 bit marks a candidate match ending at that byte), buffers it, and serialises every byte lane containing at least one 0 bit into a stream of match entries over a valid/ready handshake. It absorbs the filter's non-stallable output, signals almost-full upstream, and marks packet ends so the next stage can close per-packet state.

---
 rtl/filter_match_extract.sv | 196 +++++++++++++++++++
 tb/tb_filter_match_extract.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_match_extract.sv
// Buffers shift-or filter result words and serialises every byte lane holding a
// candidate match into a stream of (lane index, hit mask, packet-end) entries.
module filter_match_extract #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic [4:0]   out_idx,
  output logic [7:0]   out_hit,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         almost_full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // A lane is pending when any of its bits is 0 (a candidate match ends there).
  function automatic logic [31:0] lane_pend(input logic [255:0] w);
    logic [31:0] p;
    p = 32'd0;
    for (int b = 0; b < 32; b++) begin
      p[b] = (w[8*b +: 8] != 8'hFF);
    end
    return p;
  endfunction

  // Descending scan so the lowest set bit is the one left standing.
  function automatic logic [4:0] lowest_idx(input logic [31:0] p);
    logic [4:0] idx;
    idx = 5'd0;
    for (int b = 31; b >= 0; b--) begin
      idx = p[b] ? 5'(b) : idx;
    end
    return idx;
  endfunction

  logic [256:0]   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  count_r, count_nxt_s;
  logic           push_s, drop_s, pop_s, fifo_ne_s;
  logic [256:0]   head_s;

  state_t         state_r, state_nxt_s;
  logic [255:0]   word_r;
  logic           last_r;
  logic [31:0]    pend_r;
  logic [4:0]     idx_s;
  logic [7:0]     hit_s;
  logic           one_left_s, fire_s, retire_s, clr_s;
  logic           afull_r, ovf_r;

  // A full FIFO refuses the write even if the scanner pops on the same edge.
  assign push_s    = in_valid && (count_r < DEPTH_C);
  assign drop_s    = in_valid && !(count_r < DEPTH_C);
  assign fifo_ne_s = (count_r != {CW{1'b0}});
  assign head_s    = mem_r[rd_ptr_r];

  assign idx_s      = lowest_idx(pend_r);
  assign hit_s      = ~word_r[{idx_s, 3'b000} +: 8];
  assign one_left_s = (pend_r != 32'd0) && ((pend_r & (pend_r - 32'd1)) == 32'd0);

  assign almost_full = afull_r;
  assign overflow    = ovf_r;

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; data words carry no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_last, in_data};
    end
  end

  // FIFO pointers, occupancy and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      afull_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      afull_r <= (count_nxt_s >= AFULL_C);
      ovf_r   <= ovf_r | drop_s;
    end
  end

  // Scanner state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, FIFO pop and entry outputs from the scanner contents.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    clr_s       = 1'b0;
    fire_s      = 1'b0;
    retire_s    = 1'b0;
    out_valid   = 1'b0;
    out_idx     = 5'd0;
    out_hit     = 8'd0;
    out_last    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fifo_ne_s) begin
          pop_s       = 1'b1;
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (pend_r != 32'd0) begin
          out_valid = 1'b1;
          out_idx   = idx_s;
          out_hit   = hit_s;
          out_last  = last_r && one_left_s;
        end else if (last_r) begin
          // Hit-free packet end still needs a marker entry.
          out_valid = 1'b1;
          out_last  = 1'b1;
        end else begin
          out_valid = 1'b0;
        end
        fire_s   = out_valid && out_ready;
        retire_s = ((pend_r == 32'd0) && !last_r) ||
                   (fire_s && ((pend_r == 32'd0) || one_left_s));
        if (retire_s) begin
          if (fifo_ne_s) begin
            pop_s       = 1'b1;
            state_nxt_s = SCAN;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          clr_s = fire_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Scanner word, packet-end flag and pending-lane vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= 256'd0;
      last_r <= 1'b0;
      pend_r <= 32'd0;
    end else if (pop_s) begin
      word_r <= head_s[255:0];
      last_r <= head_s[256];
      pend_r <= lane_pend(head_s[255:0]);
    end else if (clr_s) begin
      pend_r[idx_s] <= 1'b0;
    end else begin
      pend_r <= pend_r;
    end
  end

endmodule

// File: tb/tb_filter_match_extract.sv
// Directed bench for filter_match_extract: expected entries are queued by the
// stimulus and a negedge monitor pops and compares each accepted entry.
module tb_filter_match_extract;

  logic         clk;
  logic         rst_n;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic [4:0]   out_idx;
  logic [7:0]   out_hit;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         almost_full;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic        hold_r = 1'b0;
  logic [13:0] held_r = 14'd0;

  filter_match_extract #(.DEPTH(8), .AFULL_LVL(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .out_idx(out_idx), .out_hit(out_hit), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .almost_full(almost_full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [255:0] d, input logic l);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_entry(input logic [4:0] idx, input logic [7:0] hit, input logic last);
    exp_q.push_back({idx, hit, last});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: scoreboard compare on every handshake, stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_r = 1'b0;
    end else begin
      if (hold_r) begin
        chk("stall_stable", {out_valid, out_idx, out_hit, out_last}, {1'b1, held_r});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", {out_idx, out_hit, out_last}, 14'h3FFF);
        end else begin
          chk("entry", {out_idx, out_hit, out_last}, exp_q.pop_front());
        end
      end
      hold_r = out_valid && !out_ready;
      held_r = {out_idx, out_hit, out_last};
    end
  end

  initial begin
    logic [255:0] w;
    rst_n     = 1'b0;
    in_data   = 256'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("reset_outs", {out_valid, out_idx, out_hit, out_last, almost_full, overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(2);

    // All-0xFF, not last: nothing emitted, FIFO empty two edges later.
    send({32{8'hFF}}, 1'b0);
    cycles(1);
    chk("nohit_count", dut.count_r, 0);
    chk("nohit_valid", out_valid, 0);
    cycles(2);
    chk("nohit_idle", out_valid, 0);

    // Lane 0 and lane 31 hits, last word.
    w = {32{8'hFF}};
    w[7:0]     = 8'hFE;
    w[255:248] = 8'h7F;
    expect_entry(5'd0, 8'h01, 1'b0);
    expect_entry(5'd31, 8'h80, 1'b1);
    send(w, 1'b1);
    chk("lat_before_load", out_valid, 0);
    cycles(1);
    chk("lat_first", {out_valid, out_idx, out_hit, out_last}, {1'b1, 5'd0, 8'h01, 1'b0});
    cycles(1);
    chk("second_entry", {out_valid, out_idx, out_hit, out_last}, {1'b1, 5'd31, 8'h80, 1'b1});
    wait_drain("drain_two", 10);

    // All-zero word then a single-hit word: 33 entries with no bubble.
    for (int b = 0; b < 32; b++) begin
      expect_entry(5'(b), 8'hFF, (b == 31) ? 1'b1 : 1'b0);
    end
    expect_entry(5'd3, 8'h0F, 1'b0);
    send({32{8'h00}}, 1'b1);
    w = {32{8'hFF}};
    w[31:24] = 8'hF0;
    send(w, 1'b0);
    for (int i = 0; i < 33; i++) begin
      chk("no_bubble", out_valid, 1);
      cycles(1);
    end
    wait_drain("drain_burst", 10);

    // Backpressure for 5 cycles.
    out_ready = 1'b0;
    w = {32{8'hFF}};
    w[23:16] = 8'h00;
    w[79:72] = 8'hFE;
    expect_entry(5'd2, 8'hFF, 1'b0);
    expect_entry(5'd9, 8'h01, 1'b1);
    send(w, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      chk("bp_hold", {out_valid, out_idx, out_hit, out_last}, {1'b1, 5'd2, 8'hFF, 1'b0});
    end
    out_ready = 1'b1;
    wait_drain("drain_bp", 10);

    // Hit-free packet end.
    expect_entry(5'd0, 8'h00, 1'b1);
    send({32{8'hFF}}, 1'b1);
    wait_drain("drain_endonly", 10);
    cycles(2);

    // Overflow: 10 words with the scanner stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      w = {32{8'hFF}};
      w[8*i +: 8] = ~8'(i);
      if (i <= 9) expect_entry(5'(i), 8'(i), 1'b0);
      send(w, 1'b0);
      chk("afull_level", almost_full, (i >= 6) ? 1 : 0);
      chk("ovf_level", overflow, (i >= 10) ? 1 : 0);
    end
    chk("ovf_count", dut.count_r, 8);
    out_ready = 1'b1;
    wait_drain("drain_ovf", 30);
    cycles(3);
    chk("ovf_sticky", {overflow, almost_full, out_valid}, 3'b100);

    // Reset while an entry is pending.
    out_ready = 1'b0;
    w = {32{8'hFF}};
    w[39:32] = 8'hEF;
    send(w, 1'b0);
    cycles(1);
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, almost_full, overflow}, 3'b000);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    w = {32{8'hFF}};
    w[63:56] = 8'h3C;
    expect_entry(5'd7, 8'hC3, 1'b1);
    send(w, 1'b1);
    wait_drain("drain_post_reset", 10);
    cycles(3);
    chk("final_idle", {out_valid, overflow}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
